fpro_bus_master: RTL and testbench
==================================

Name: fpro_bus_master

Overview:
- Hardware initiator for the FPro MMIO bus. It drives mmio_cs/mmio_wr/mmio_rd/mmio_addr/mmio_wr_data into an mmio subsystem and samples mmio_rd_data.
- Lets hardware sequencers (e.g. a UART command bridge) perform single writes, single reads, and masked poll-until-match reads with timeout, without the processor.
- Front side: a valid/ready command channel and a valid/ready response channel.

Parameters:
- POLL_GAP, 16, idle cycles between consecutive poll strobes; minimum 1.
- TIMEOUT_W, 16, poll attempt counter width; at most 2^TIMEOUT_W strobes per poll command.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal
- cmd_addr  in  21  FPro address; addr[10:5] slot, addr[4:0] register
- cmd_wr_data  in  32  write data (write); match value (poll)
- cmd_mask  in  32  poll compare mask; ignored otherwise
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read/poll data; 0 for write/illegal
- rsp_timeout  out  1  poll exhausted attempts
- rsp_err  out  1  illegal opcode
- mmio_cs  out  1  bus chip select
- mmio_wr  out  1  bus write strobe
- mmio_rd  out  1  bus read strobe
- mmio_addr  out  21  bus address
- mmio_wr_data  out  32  bus write data
- mmio_rd_data  in  32  bus read data (combinational from responder)

Behaviour:
- One clock, clk; reset is synchronous and active-high. Reset forces IDLE and clears all registered outputs: mmio_cs/wr/rd=0, mmio_addr=0, mmio_wr_data=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, rsp_err=0, all counters=0.
- cmd_ready = (state==IDLE). It is 0 in every other state, so there is no command queueing.
- States: IDLE, STROBE, GAP, RESP.
- IDLE: on cmd_valid&&cmd_ready, latch op/addr/data/mask and clear attempt counter.
  - Ops 00/01/10 go to STROBE.
  - Op 11 goes directly to RESP with rsp_err=1, rsp_data=0, and no bus cycle.
- Bus outputs are registered. mmio_cs=1 with exactly one of mmio_wr/mmio_rd for exactly one cycle (STROBE); all strobes are 0 in every other state.
  - mmio_addr holds the latched address during STROBE and 0 otherwise.
  - mmio_wr_data is the latched data only during a write STROBE, else 0.
- Read data is sampled on the clock edge that ends STROBE.
- STROBE exit:
  - Write: go to RESP with rsp_data=0.
  - Read: go to RESP with rsp_data=mmio_rd_data.
  - Poll: compute (mmio_rd_data & mask) == (match & mask).
    - Match: RESP with rsp_data=sample, rsp_timeout=0.
    - Mismatch with attempt counter == 2^TIMEOUT_W-1: RESP with rsp_data=last sample, rsp_timeout=1.
    - Mismatch otherwise: increment counter and go to GAP.
- GAP: count POLL_GAP cycles, then go to STROBE. Retry strobe spacing is POLL_GAP+1 cycles rising-to-rising.
- Latency for write/read/first-poll-match: accept edge T0, strobe cycle T1, rsp_valid high from T2.
- RESP: rsp_valid=1; rsp_data/rsp_timeout/rsp_err held stable until the rsp_valid&&rsp_ready edge, then back to IDLE.
  - Response flags clear on leaving RESP.
  - The next command can be accepted the cycle after the handshake.
- Mask 0 on poll matches on the first attempt.
- Reset mid-operation abandons the command with no response; strobes are 0 from the reset edge onward.
- Address and data are passed through unmodified; the block performs no slot decoding.

Decomposition:
- Package fpro_master_pkg holds:
  - cmd_op_t enum: OP_WR, OP_RD, OP_POLL, OP_ILL.
  - state_t enum: IDLE, STROBE, GAP, RESP.
  - Constants FPRO_ADDR_W=21, FPRO_DATA_W=32.
- Single module, no sub-module; the gap and attempt counters are inline.

Test Plan (bench pairs the block with mmio_sys_vanilla, N_LED=4, N_SW=8, POLL_GAP=4):
- Write 0x040 data 0x5 -> one cycle cs=1 wr=1 addr=0x040 wr_data=0x5 at T1; led=4'b0101; rsp_valid at T2, rsp_data=0, flags 0.
- sw=8'hA5, read 0x060 -> single rd strobe at T1; rsp_data=0x000000A5 at T2.
- sw=0, poll 0x060 mask 0x1 match 0x1; set sw[0]=1 after the 3rd strobe -> strobes 5 cycles apart; response after 4th strobe, rsp_data=0x1, rsp_timeout=0.
- TIMEOUT_W=3, sw=0, poll 0x060 mask 0x1 match 0x1 -> exactly 8 strobes, then rsp_timeout=1, rsp_data=0.
- rsp_ready low 5 cycles after write response -> rsp_valid/rsp_data stable, cmd_ready=0, no bus activity; after the handshake cycle, op 11 is accepted next cycle -> rsp_err=1, rsp_data=0, no strobe.
- Reset asserted during GAP of a poll -> no rsp_valid, strobes remain 0, all outputs at reset values, cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/fpro_master_pkg.sv
// Shared types and constants for the FPro MMIO bus master.
package fpro_master_pkg;

  localparam int FPRO_ADDR_W = 21;
  localparam int FPRO_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_ILL  = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP,
    RESP
  } state_t;

endpackage

// File: rtl/fpro_bus_master.sv
// FPro MMIO bus initiator: single write/read and masked poll-until-match with
// timeout, driven from a valid/ready command channel with a valid/ready response.
module fpro_bus_master
  import fpro_master_pkg::*;
#(
  parameter int POLL_GAP  = 16,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [FPRO_ADDR_W-1:0] cmd_addr,
  input  logic [FPRO_DATA_W-1:0] cmd_wr_data,
  input  logic [FPRO_DATA_W-1:0] cmd_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [FPRO_DATA_W-1:0] rsp_data,
  output logic                   rsp_timeout,
  output logic                   rsp_err,
  output logic                   mmio_cs,
  output logic                   mmio_wr,
  output logic                   mmio_rd,
  output logic [FPRO_ADDR_W-1:0] mmio_addr,
  output logic [FPRO_DATA_W-1:0] mmio_wr_data,
  input  logic [FPRO_DATA_W-1:0] mmio_rd_data
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_t                 state_q, state_d;
  cmd_op_t                op_q, op_d;
  logic [FPRO_ADDR_W-1:0] addr_q, addr_d;
  logic [FPRO_DATA_W-1:0] data_q, data_d;
  logic [FPRO_DATA_W-1:0] mask_q, mask_d;
  logic [TIMEOUT_W-1:0]   attempt_q, attempt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;

  logic                   cs_d, wr_d, rd_d;
  logic [FPRO_ADDR_W-1:0] bus_addr_d;
  logic [FPRO_DATA_W-1:0] bus_wdata_d;
  logic                   rsp_valid_d, rsp_to_d, rsp_err_d;
  logic [FPRO_DATA_W-1:0] rsp_data_d;
  logic                   poll_hit;

  assign cmd_ready = (state_q == IDLE);
  assign poll_hit  = ((mmio_rd_data ^ data_q) & mask_q) == '0;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    attempt_d   = attempt_q;
    gap_d       = gap_q;
    cs_d        = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    bus_addr_d  = '0;
    bus_wdata_d = '0;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_to_d    = rsp_timeout;
    rsp_err_d   = rsp_err;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op_t'(cmd_op);
          addr_d    = cmd_addr;
          data_d    = cmd_wr_data;
          mask_d    = cmd_mask;
          attempt_d = '0;
          if (cmd_op_t'(cmd_op) == OP_ILL) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            // Strobe outputs are registered, so they are loaded on the accept edge.
            state_d     = STROBE;
            cs_d        = 1'b1;
            wr_d        = (cmd_op_t'(cmd_op) == OP_WR);
            rd_d        = (cmd_op_t'(cmd_op) != OP_WR);
            bus_addr_d  = cmd_addr;
            bus_wdata_d = (cmd_op_t'(cmd_op) == OP_WR) ? cmd_wr_data : '0;
          end
        end
      end
      STROBE: begin
        unique case (op_q)
          OP_WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end
          OP_RD: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = mmio_rd_data;
          end
          default: begin
            if (poll_hit || (&attempt_q)) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = mmio_rd_data;
              rsp_to_d    = !poll_hit;
            end else begin
              state_d   = GAP;
              attempt_d = attempt_q + 1'b1;
              gap_d     = '0;
            end
          end
        endcase
      end
      GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          state_d    = STROBE;
          cs_d       = 1'b1;
          rd_d       = 1'b1;
          bus_addr_d = addr_q;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_to_d    = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_WR;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      attempt_q    <= '0;
      gap_q        <= '0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      attempt_q    <= attempt_d;
      gap_q        <= gap_d;
      mmio_cs      <= cs_d;
      mmio_wr      <= wr_d;
      mmio_rd      <= rd_d;
      mmio_addr    <= bus_addr_d;
      mmio_wr_data <= bus_wdata_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_timeout  <= rsp_to_d;
      rsp_err      <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_fpro_bus_master.sv
// Bench for fpro_bus_master: behavioural MMIO responder plus directed and random commands.
module tb_fpro_bus_master;

  localparam int GAPC  = 4;
  localparam int TW    = 3;
  localparam int NPOLL = 1 << TW;

  logic        clk = 0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [20:0] cmd_addr;
  logic [31:0] cmd_wr_data, cmd_mask;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout, rsp_err;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data, mmio_rd_data;

  fpro_bus_master #(.POLL_GAP(GAPC), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_err(rsp_err),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder: word memory keyed by low address byte, switch register at 0x060,
  // and a scripted value sequence (one per strobe) while a poll is running.
  bit   [31:0] mem [256];
  logic [7:0]  sw;
  logic [31:0] poll_vals [NPOLL];
  logic        poll_mode;
  int          poll_base;
  int          nstrobe = 0;
  int          cyc = 0;
  int          pidx;

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (mmio_cs) nstrobe <= nstrobe + 1;
    if (mmio_cs && mmio_wr) mem[mmio_addr[7:0]] <= mmio_wr_data;
  end

  always_comb begin
    pidx = nstrobe - poll_base;
    if (pidx < 0) pidx = 0;
    if (pidx > NPOLL - 1) pidx = NPOLL - 1;
    if (poll_mode) mmio_rd_data = poll_vals[pidx];
    else if (mmio_addr[7:0] == 8'h60) mmio_rd_data = {24'b0, sw};
    else mmio_rd_data = mem[mmio_addr[7:0]];
  end

  // Strobe log, sampled mid-cycle.
  int          s_cyc [$];
  logic        s_wr [$];
  logic        s_rd [$];
  logic [20:0] s_addr [$];
  logic [31:0] s_wdata [$];
  int          idle_viol = 0;

  always @(negedge clk) begin
    if (mmio_cs) begin
      s_cyc.push_back(cyc);
      s_wr.push_back(mmio_wr);
      s_rd.push_back(mmio_rd);
      s_addr.push_back(mmio_addr);
      s_wdata.push_back(mmio_wr_data);
    end else if (mmio_wr || mmio_rd || mmio_addr != 0 || mmio_wr_data != 0) begin
      idle_viol = idle_viol + 1;
    end
  end

  // Reference state: address pool and last written value per pool entry.
  logic [20:0] pool [16];
  logic [31:0] ref_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [1:0] op, input int idx, input logic [31:0] d,
                     input logic [31:0] m, input int hold);
    int exp_n, exp_lat, ns0, t0, waited, got, t_rsp;
    logic [31:0] exp_data, rd0;
    logic exp_to, exp_err, found, stable;
    exp_to = 0; exp_err = 0; exp_data = 0; exp_n = 1; exp_lat = 1;
    case (op)
      2'b00: exp_data = 0;
      2'b01: exp_data = (idx == 1) ? {24'b0, sw} : ref_mem[idx];
      2'b10: begin
        exp_n = NPOLL; exp_to = 1; exp_data = poll_vals[NPOLL-1]; found = 0;
        for (int i = 0; i < NPOLL; i++)
          if (!found && (((poll_vals[i] ^ d) & m) == 0)) begin
            found = 1; exp_n = i + 1; exp_to = 0; exp_data = poll_vals[i];
          end
        exp_lat = (GAPC + 1) * (exp_n - 1) + 1;
      end
      default: begin exp_n = 0; exp_err = 1; exp_lat = 0; end
    endcase
    @(negedge clk);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    ns0 = s_cyc.size();
    poll_base = nstrobe;
    poll_mode = (op == 2'b10);
    cmd_valid = 1; cmd_op = op; cmd_addr = pool[idx]; cmd_wr_data = d; cmd_mask = m;
    @(posedge clk); #1;
    t0 = cyc;
    cmd_valid = 0;
    waited = 0; got = 0;
    while (!got && waited < 300) begin
      @(negedge clk);
      if (rsp_valid) got = 1; else waited++;
    end
    chk("rsp_seen", got, 1);
    t_rsp = cyc;
    chk("rsp_latency", t_rsp - t0, exp_lat);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    rd0 = rsp_data; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_data === rd0 && cmd_ready === 1'b0)) stable = 0;
    end
    chk("rsp_hold_stable", {31'b0, stable}, 1);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    chk("rsp_cleared", {29'b0, rsp_valid, rsp_timeout, rsp_err}, 0);
    chk("cmd_ready_after", {31'b0, cmd_ready}, 1);
    chk("n_strobes", s_cyc.size() - ns0, exp_n);
    for (int i = 0; i < exp_n && ns0 + i < s_cyc.size(); i++) begin
      chk("strobe_cycle", s_cyc[ns0+i] - t0, (GAPC + 1) * i);
      chk("strobe_kind", {30'b0, s_wr[ns0+i], s_rd[ns0+i]}, (op == 2'b00) ? 2 : 1);
      chk("strobe_addr", {11'b0, s_addr[ns0+i]}, {11'b0, pool[idx]});
      chk("strobe_wdata", s_wdata[ns0+i], (op == 2'b00) ? d : 0);
    end
    poll_mode = 0;
    if (op == 2'b00) ref_mem[idx] = d;
  endtask

  initial begin
    int idx, op, ns0, got, waited, bad;
    logic [31:0] d, m;
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wr_data = 0; cmd_mask = 0;
    rsp_ready = 0; sw = 0; poll_mode = 0; poll_base = 0;
    for (int i = 0; i < NPOLL; i++) poll_vals[i] = 0;
    pool[0] = 21'h040;
    pool[1] = 21'h060;
    for (int i = 2; i < 16; i++) pool[i] = {13'($urandom), 8'(i * 16 + 5)};
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 1);
    chk("reset_rsp", {29'b0, rsp_valid, rsp_timeout, rsp_err}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_bus", {29'b0, mmio_cs, mmio_wr, mmio_rd}, 0);

    // Directed: LED write, switch read, poll matching on 4th strobe, poll timeout.
    run(2'b00, 0, 32'h5, 32'h0, 0);
    chk("led_value", {28'b0, mem[8'h40][3:0]}, 32'h5);
    sw = 8'hA5;
    run(2'b01, 1, 32'h0, 32'h0, 0);
    for (int i = 0; i < NPOLL; i++) poll_vals[i] = (i >= 3) ? 32'h1 : 32'h0;
    run(2'b10, 1, 32'h1, 32'h1, 0);
    for (int i = 0; i < NPOLL; i++) poll_vals[i] = 0;
    run(2'b10, 1, 32'h1, 32'h1, 0);
    // Backpressured write response, then illegal op straight after the handshake.
    run(2'b00, 0, 32'hA, 32'h0, 5);
    run(2'b11, 3, 32'hDEAD, 32'h0, 0);
    // Mask 0 must match on the first attempt regardless of data.
    for (int i = 0; i < NPOLL; i++) poll_vals[i] = $urandom;
    run(2'b10, 5, $urandom, 32'h0, 1);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      idx = $urandom_range(0, 15);
      if (op == 0 && idx == 1) idx = 2;
      d = $urandom;
      case ($urandom_range(0, 3))
        0: m = 0;
        1: m = 32'h1 << $urandom_range(0, 31);
        default: m = $urandom;
      endcase
      sw = 8'($urandom);
      for (int i = 0; i < NPOLL; i++)
        poll_vals[i] = ($urandom_range(0, 3) == 0) ? ((d & m) | ($urandom & ~m)) : $urandom;
      run(2'(op), idx, d, m, $urandom_range(0, 3));
    end

    // Reset while a poll is waiting in its gap.
    for (int i = 0; i < NPOLL; i++) poll_vals[i] = 0;
    @(negedge clk);
    poll_base = nstrobe; poll_mode = 1;
    cmd_valid = 1; cmd_op = 2'b10; cmd_addr = pool[1]; cmd_wr_data = 1; cmd_mask = 1;
    @(posedge clk); #1 cmd_valid = 0;
    got = 0; waited = 0;
    while (!got && waited < 100) begin
      @(negedge clk);
      if (nstrobe - poll_base >= 2) got = 1; else waited++;
    end
    chk("poll_reached_gap", got, 1);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midreset_bus", {29'b0, mmio_cs, mmio_wr, mmio_rd}, 0);
    chk("midreset_addr", {11'b0, mmio_addr}, 0);
    chk("midreset_wdata", mmio_wr_data, 0);
    chk("midreset_rsp", {29'b0, rsp_valid, rsp_timeout, rsp_err}, 0);
    chk("midreset_rsp_data", rsp_data, 0);
    @(negedge clk);
    reset = 0;
    ns0 = s_cyc.size();
    @(negedge clk);
    chk("postreset_cmd_ready", {31'b0, cmd_ready}, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    chk("postreset_quiet", bad, 0);
    chk("postreset_no_strobe", s_cyc.size() - ns0, 0);
    poll_mode = 0;
    run(2'b00, 4, 32'h1234_5678, 32'h0, 0);
    run(2'b01, 4, 32'h0, 32'h0, 0);
    chk("bus_idle_zero", idle_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
